// File: rtl/bus_arbiter_pkg.sv
// Shared types and the round-robin search used by the system bus arbiter.
// The search walks from last+1 upward, wrapping modulo the leader count.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] DefaultErrorData = 32'hDEADBEEF;
    localparam int          MaxLeaders       = 8;

    function automatic logic [2:0] next_rr(
        input logic [MaxLeaders-1:0] req,
        input logic [2:0]            last,
        input int                    n
    );
        logic [2:0]  win;
        logic        hit;
        logic [31:0] idx;
        win = '0;
        hit = 1'b0;
        for (int i = 1; i <= MaxLeaders; i++) begin
            idx = 32'((int'(last) + i) % n);
            if (!hit && (i <= n) && req[idx[2:0]]) begin
                win = idx[2:0];
                hit = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest requester after i_last, wrapping.
// Zero latency; o_found is low when nobody requests.
module rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int Leaders = 2,
    parameter int IdxW    = $clog2(Leaders)
) (
    input  logic [Leaders-1:0] i_req,
    input  logic [IdxW-1:0]    i_last,
    output logic [IdxW-1:0]    o_winner,
    output logic               o_found
);

    logic [MaxLeaders-1:0] w_req_ext;
    logic [2:0]            w_last_ext;
    logic [2:0]            w_pick;

    assign w_req_ext  = MaxLeaders'(i_req);
    assign w_last_ext = 3'(i_last);
    assign w_pick     = next_rr(w_req_ext, w_last_ext, Leaders);
    assign o_winner   = IdxW'(w_pick);
    assign o_found    = |i_req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system bus leader port; requests pass through with zero latency.
// A read holds the bus until its data returns or a timeout fires; other leaders stall meanwhile.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          Leaders       = 2,
    parameter int          TimeoutCycles = 255,
    parameter logic [31:0] ErrorData     = DefaultErrorData
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [Leaders-1:0][31:0] leaders_addr,
    input  logic [Leaders-1:0]       leaders_read_req,
    input  logic [Leaders-1:0]       leaders_write_req,
    input  logic [Leaders-1:0][3:0]  leaders_byte_enable,
    input  logic [Leaders-1:0][31:0] leaders_write_data,
    output logic [Leaders-1:0][31:0] leaders_read_data,
    output logic [Leaders-1:0]       leaders_read_data_valid,
    output logic [31:0]              downstream_addr,
    output logic                     downstream_read_req,
    output logic                     downstream_write_req,
    output logic [3:0]               downstream_byte_enable,
    output logic [31:0]              downstream_write_data,
    input  logic [31:0]              downstream_read_data,
    input  logic                     downstream_read_data_valid,
    output logic [Leaders-1:0]       accept,
    output logic [Leaders-1:0]       grant,
    output logic                     timeout
);

    localparam int IdxW = $clog2(Leaders);
    localparam int CntW = $clog2(TimeoutCycles + 1);

    state_t          r_state;
    logic [IdxW-1:0] r_last;
    logic [IdxW-1:0] r_owner;
    logic [CntW-1:0] r_cnt;

    logic [Leaders-1:0] w_req;
    logic [IdxW-1:0]    w_win;
    logic               w_found;
    logic               w_issue;
    logic               w_win_rd;
    logic               w_tmo;

    assign w_req = leaders_read_req | leaders_write_req;

    rr_picker #(.Leaders(Leaders)) u_picker (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_winner (w_win),
        .o_found  (w_found)
    );

    // Gating with reset_n keeps every output quiet while reset is held.
    assign w_issue  = (r_state == IDLE) && w_found && reset_n;
    assign w_win_rd = leaders_read_req[w_win] & ~leaders_write_req[w_win];
    assign w_tmo    = (r_state == READ_WAIT) && !downstream_read_data_valid &&
                      (r_cnt == CntW'(TimeoutCycles - 1));

    always_comb begin
        downstream_addr         = '0;
        downstream_read_req     = 1'b0;
        downstream_write_req    = 1'b0;
        downstream_byte_enable  = '0;
        downstream_write_data   = '0;
        leaders_read_data       = '0;
        leaders_read_data_valid = '0;
        accept                  = '0;
        grant                   = '0;
        timeout                 = 1'b0;
        if (w_issue) begin
            downstream_addr        = leaders_addr[w_win];
            downstream_read_req    = w_win_rd;
            downstream_write_req   = leaders_write_req[w_win];
            downstream_byte_enable = leaders_byte_enable[w_win];
            downstream_write_data  = leaders_write_data[w_win];
            accept[w_win]          = 1'b1;
            grant[w_win]           = 1'b1;
        end
        if (r_state == READ_WAIT) begin
            grant[r_owner]                   = 1'b1;
            leaders_read_data[r_owner]       = w_tmo ? ErrorData : downstream_read_data;
            leaders_read_data_valid[r_owner] = downstream_read_data_valid | w_tmo;
            timeout                          = w_tmo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= IdxW'(Leaders - 1);
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_last <= w_win;
                        if (w_win_rd) begin
                            r_owner <= w_win;
                            r_cnt   <= '0;
                            r_state <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    // Real data beats the timeout when both land in the same cycle.
                    if (downstream_read_data_valid || w_tmo) begin
                        r_state <= IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter with two leaders and a short read timeout.
module tb_bus_arbiter;

    localparam int          NL  = 2;
    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic                clk;
    logic                reset_n;
    logic [NL-1:0][31:0] leaders_addr;
    logic [NL-1:0]       leaders_read_req;
    logic [NL-1:0]       leaders_write_req;
    logic [NL-1:0][3:0]  leaders_byte_enable;
    logic [NL-1:0][31:0] leaders_write_data;
    logic [NL-1:0][31:0] leaders_read_data;
    logic [NL-1:0]       leaders_read_data_valid;
    logic [31:0]         downstream_addr;
    logic                downstream_read_req;
    logic                downstream_write_req;
    logic [3:0]          downstream_byte_enable;
    logic [31:0]         downstream_write_data;
    logic [31:0]         downstream_read_data;
    logic                downstream_read_data_valid;
    logic [NL-1:0]       accept;
    logic [NL-1:0]       grant;
    logic                timeout;

    int checks   = 0;
    int failures = 0;
    logic [3:0] led = 4'h0;

    bus_arbiter #(.Leaders(NL), .TimeoutCycles(TMO), .ErrorData(ERR)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .leaders_addr               (leaders_addr),
        .leaders_read_req           (leaders_read_req),
        .leaders_write_req          (leaders_write_req),
        .leaders_byte_enable        (leaders_byte_enable),
        .leaders_write_data         (leaders_write_data),
        .leaders_read_data          (leaders_read_data),
        .leaders_read_data_valid    (leaders_read_data_valid),
        .downstream_addr            (downstream_addr),
        .downstream_read_req        (downstream_read_req),
        .downstream_write_req       (downstream_write_req),
        .downstream_byte_enable     (downstream_byte_enable),
        .downstream_write_data      (downstream_write_data),
        .downstream_read_data       (downstream_read_data),
        .downstream_read_data_valid (downstream_read_data_valid),
        .accept                     (accept),
        .grant                      (grant),
        .timeout                    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED register follower at 0x10000000, low nibble of byte lane 0.
    always @(posedge clk)
        if (downstream_write_req && downstream_addr == 32'h10000000 && downstream_byte_enable[0])
            led <= downstream_write_data[3:0];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        leaders_addr               = '0;
        leaders_read_req           = '0;
        leaders_write_req          = '0;
        leaders_byte_enable        = '0;
        leaders_write_data         = '0;
        downstream_read_data       = '0;
        downstream_read_data_valid = 1'b0;
    endtask

    task automatic set_leader(input int i, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        leaders_read_req[i]    = rd;
        leaders_write_req[i]   = wr;
        leaders_addr[i]        = a;
        leaders_byte_enable[i] = be;
        leaders_write_data[i]  = wd;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b1;
        #1;
        set_leader(0, 1'b0, 1'b1, 32'h10000000, 4'hF, 32'h1);
        reset_n = 1'b0;
        #1;
        checks++; if (accept !== 2'b00) begin failures++; $display("FAIL reset_accept got=%b exp=00", accept); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if ({downstream_read_req, downstream_write_req, downstream_addr, downstream_write_data} !== 66'h0)
            begin failures++; $display("FAIL reset_downstream got wr=%b addr=%h exp all zero", downstream_write_req, downstream_addr); end
        checks++; if (leaders_read_data_valid !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", leaders_read_data_valid); end
        @(negedge clk);
        clear_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        set_leader(0, 1'b0, 1'b1, 32'h10000000, 4'h1, 32'h5);
        #1;
        checks++; if (downstream_write_req !== 1'b1 || downstream_read_req !== 1'b0)
            begin failures++; $display("FAIL wr_req got wr=%b rd=%b exp wr=1 rd=0", downstream_write_req, downstream_read_req); end
        checks++; if (downstream_addr !== 32'h10000000 || downstream_byte_enable !== 4'h1 || downstream_write_data !== 32'h5)
            begin failures++; $display("FAIL wr_fields got addr=%h be=%h wd=%h exp 10000000/1/5", downstream_addr, downstream_byte_enable, downstream_write_data); end
        checks++; if (accept !== 2'b01 || grant !== 2'b01) begin failures++; $display("FAIL wr_accept got acc=%b gnt=%b exp 01/01", accept, grant); end
        tick();
        clear_inputs();
        #1;
        checks++; if (led !== 4'h5) begin failures++; $display("FAIL wr_led got=%h exp=5", led); end
        checks++; if (accept !== 2'b00) begin failures++; $display("FAIL wr_accept_pulse got=%b exp=00", accept); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        set_leader(1, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0);
        #1;
        checks++; if (accept !== 2'b10 || grant !== 2'b10 || downstream_read_req !== 1'b1)
            begin failures++; $display("FAIL rd_issue got acc=%b gnt=%b rd=%b exp 10/10/1", accept, grant, downstream_read_req); end
        tick();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (grant !== 2'b10 || accept !== 2'b00 || downstream_read_req !== 1'b0)
                begin failures++; $display("FAIL rd_hold got gnt=%b acc=%b rd=%b exp 10/00/0", grant, accept, downstream_read_req); end
            tick();
        end
        downstream_read_data_valid = 1'b1;
        downstream_read_data       = 32'h0000000A;
        #1;
        checks++; if (leaders_read_data_valid !== 2'b10) begin failures++; $display("FAIL rd_valid got=%b exp=10", leaders_read_data_valid); end
        checks++; if (leaders_read_data[1] !== 32'h0000000A) begin failures++; $display("FAIL rd_data got=%h exp=0000000a", leaders_read_data[1]); end
        checks++; if (leaders_read_data[0] !== 32'h0) begin failures++; $display("FAIL rd_other_data got=%h exp=0", leaders_read_data[0]); end
        tick();
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rd_release got=%b exp=00", grant); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [31:0] seq [NL];
        int          w;
        apply_reset();
        seq[0] = 32'hA000_0000;
        seq[1] = 32'hB000_0000;
        for (int c = 0; c < 6; c++) begin
            set_leader(0, 1'b0, 1'b1, 32'h40000000, 4'hF, seq[0]);
            set_leader(1, 1'b0, 1'b1, 32'h40000004, 4'hF, seq[1]);
            w = c % 2;
            #1;
            checks++; if (accept !== 2'(1 << w)) begin failures++; $display("FAIL contention_accept cycle=%0d got=%b exp leader %0d", c, accept, w); end
            checks++; if (downstream_write_data !== seq[w]) begin failures++; $display("FAIL contention_data cycle=%0d got=%h exp=%h", c, downstream_write_data, seq[w]); end
            seq[w] = seq[w] + 1;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_read_stall();
        set_leader(0, 1'b1, 1'b0, 32'h20000004, 4'hF, 32'h0);
        set_leader(1, 1'b0, 1'b1, 32'h10000000, 4'hF, 32'h7);
        #1;
        checks++; if (accept !== 2'b01 || downstream_read_req !== 1'b1) begin failures++; $display("FAIL stall_issue got acc=%b rd=%b exp 01/1", accept, downstream_read_req); end
        tick();
        leaders_read_req[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (accept !== 2'b00 || downstream_write_req !== 1'b0 || grant !== 2'b01)
                begin failures++; $display("FAIL stall_block got acc=%b wr=%b gnt=%b exp 00/0/01", accept, downstream_write_req, grant); end
            tick();
        end
        downstream_read_data_valid = 1'b1;
        downstream_read_data       = 32'h0000000B;
        #1;
        checks++; if (leaders_read_data_valid !== 2'b01 || accept !== 2'b00)
            begin failures++; $display("FAIL stall_valid got val=%b acc=%b exp 01/00", leaders_read_data_valid, accept); end
        tick();
        downstream_read_data_valid = 1'b0;
        #1;
        checks++; if (accept !== 2'b10 || downstream_write_req !== 1'b1 || downstream_write_data !== 32'h7)
            begin failures++; $display("FAIL stall_after got acc=%b wr=%b wd=%h exp 10/1/7", accept, downstream_write_req, downstream_write_data); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        set_leader(0, 1'b1, 1'b0, 32'h30000000, 4'hF, 32'h0);
        #1;
        checks++; if (accept !== 2'b01) begin failures++; $display("FAIL tmo_issue got=%b exp=01", accept); end
        tick();
        clear_inputs();
        for (int k = 0; k < TMO; k++) begin
            #1;
            if (k < TMO - 1) begin
                checks++; if (leaders_read_data_valid !== 2'b00 || timeout !== 1'b0)
                    begin failures++; $display("FAIL tmo_early k=%0d got val=%b tmo=%b exp 00/0", k, leaders_read_data_valid, timeout); end
            end else begin
                checks++; if (leaders_read_data_valid !== 2'b01 || timeout !== 1'b1)
                    begin failures++; $display("FAIL tmo_fire got val=%b tmo=%b exp 01/1", leaders_read_data_valid, timeout); end
                checks++; if (leaders_read_data[0] !== ERR) begin failures++; $display("FAIL tmo_data got=%h exp=%h", leaders_read_data[0], ERR); end
            end
            tick();
        end
        downstream_read_data_valid = 1'b1;
        downstream_read_data       = 32'h00001234;
        #1;
        checks++; if (leaders_read_data_valid !== 2'b00 || timeout !== 1'b0)
            begin failures++; $display("FAIL tmo_late got val=%b tmo=%b exp 00/0", leaders_read_data_valid, timeout); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout_race();
        set_leader(1, 1'b1, 1'b0, 32'h20000008, 4'hF, 32'h0);
        tick();
        clear_inputs();
        for (int k = 0; k < TMO - 1; k++) tick();
        downstream_read_data_valid = 1'b1;
        downstream_read_data       = 32'h0000000C;
        #1;
        checks++; if (leaders_read_data_valid !== 2'b10 || timeout !== 1'b0)
            begin failures++; $display("FAIL race_valid got val=%b tmo=%b exp 10/0", leaders_read_data_valid, timeout); end
        checks++; if (leaders_read_data[1] !== 32'h0000000C) begin failures++; $display("FAIL race_data got=%h exp=0000000c", leaders_read_data[1]); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        set_leader(0, 1'b1, 1'b0, 32'h20000000, 4'hF, 32'h0);
        #1;
        checks++; if (accept !== 2'b01) begin failures++; $display("FAIL midrst_issue got=%b exp=01", accept); end
        tick();
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL midrst_wait got=%b exp=01", grant); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || timeout !== 1'b0 || leaders_read_data_valid !== 2'b00)
            begin failures++; $display("FAIL midrst_async got gnt=%b tmo=%b val=%b exp 00/0/00", grant, timeout, leaders_read_data_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        set_leader(0, 1'b0, 1'b1, 32'h40000000, 4'hF, 32'h1);
        set_leader(1, 1'b0, 1'b1, 32'h40000004, 4'hF, 32'h2);
        downstream_read_data_valid = 1'b1;
        downstream_read_data       = 32'h0000000A;
        #1;
        checks++; if (accept !== 2'b01) begin failures++; $display("FAIL midrst_first got=%b exp=01", accept); end
        checks++; if (leaders_read_data_valid !== 2'b00) begin failures++; $display("FAIL midrst_novalid got=%b exp=00", leaders_read_data_valid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic        p_vld [NL];
        logic        p_rd  [NL];
        logic        p_wr  [NL];
        logic [31:0] p_addr[NL];
        logic [3:0]  p_be  [NL];
        logic [31:0] p_wd  [NL];
        logic [NL-1:0] e_acc, e_gnt, e_val;
        logic          e_tmo, e_dr, e_dw;
        logic [31:0]   e_data;
        int  last, owner, waited, resp_at, w, kind;
        bit  busy;
        apply_reset();
        last = NL - 1; busy = 0; owner = 0; waited = 0; resp_at = 0;
        for (int i = 0; i < NL; i++) p_vld[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NL; i++) begin
                if (!p_vld[i] && $urandom_range(0, 2) != 0) begin
                    kind      = $urandom_range(0, 2);
                    p_vld[i]  = 1'b1;
                    p_rd[i]   = (kind != 1);
                    p_wr[i]   = (kind != 0);
                    p_addr[i] = $urandom;
                    p_be[i]   = 4'($urandom);
                    p_wd[i]   = $urandom;
                end
                if (p_vld[i]) set_leader(i, p_rd[i], p_wr[i], p_addr[i], p_be[i], p_wd[i]);
                else          set_leader(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            end
            e_acc = '0; e_gnt = '0; e_val = '0; e_tmo = 1'b0; e_dr = 1'b0; e_dw = 1'b0; e_data = '0;
            downstream_read_data       = $urandom;
            downstream_read_data_valid = 1'b0;
            w = -1;
            if (!busy) begin
                for (int s = 1; s <= NL; s++)
                    if (w < 0 && p_vld[(last + s) % NL]) w = (last + s) % NL;
                downstream_read_data_valid = ($urandom_range(0, 7) == 0);
                if (w >= 0) begin
                    e_acc[w] = 1'b1;
                    e_gnt[w] = 1'b1;
                    e_dw     = p_wr[w];
                    e_dr     = p_rd[w] && !p_wr[w];
                end
            end else begin
                e_gnt[owner] = 1'b1;
                if (waited == resp_at) begin
                    downstream_read_data_valid = 1'b1;
                    e_val[owner] = 1'b1;
                    e_data       = downstream_read_data;
                end else if (waited == TMO - 1) begin
                    e_val[owner] = 1'b1;
                    e_data       = ERR;
                    e_tmo        = 1'b1;
                end
            end
            #1;
            checks++; if (accept !== e_acc || grant !== e_gnt)
                begin failures++; $display("FAIL rand_arb cycle=%0d got acc=%b gnt=%b exp acc=%b gnt=%b", c, accept, grant, e_acc, e_gnt); end
            checks++; if (downstream_read_req !== e_dr || downstream_write_req !== e_dw)
                begin failures++; $display("FAIL rand_req cycle=%0d got rd=%b wr=%b exp rd=%b wr=%b", c, downstream_read_req, downstream_write_req, e_dr, e_dw); end
            checks++; if (leaders_read_data_valid !== e_val || timeout !== e_tmo)
                begin failures++; $display("FAIL rand_resp cycle=%0d got val=%b tmo=%b exp val=%b tmo=%b", c, leaders_read_data_valid, timeout, e_val, e_tmo); end
            if (w >= 0) begin
                checks++; if (downstream_addr !== p_addr[w] || downstream_byte_enable !== p_be[w] || downstream_write_data !== p_wd[w])
                    begin failures++; $display("FAIL rand_fields cycle=%0d got addr=%h be=%h wd=%h exp addr=%h be=%h wd=%h", c,
                        downstream_addr, downstream_byte_enable, downstream_write_data, p_addr[w], p_be[w], p_wd[w]); end
            end
            if (e_val != '0) begin
                checks++; if (leaders_read_data[owner] !== e_data)
                    begin failures++; $display("FAIL rand_rdata cycle=%0d got=%h exp=%h", c, leaders_read_data[owner], e_data); end
            end
            if (!busy && w >= 0) begin
                last     = w;
                p_vld[w] = 1'b0;
                if (e_dr) begin
                    busy    = 1;
                    owner   = w;
                    waited  = 0;
                    resp_at = $urandom_range(0, 5);
                end
            end else if (busy) begin
                if (e_val != '0) busy = 0;
                else             waited++;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_read_stall();
        test_timeout();
        test_timeout_race();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
